// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: shares the single PDP-8 memory port between instruction fetch (read) and execute (read/write).
// Define PDP8_ARB_RR_EN for IFU/EXEC round-robin; without it priority is fixed at exec_wr > exec_rd > ifu_rd.
module pdp8_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  output logic                  ifu_stall,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_done,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  proto_err
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IFU_RD, OWN_EXEC_RD, OWN_EXEC_WR} owner_t;

  state_t                state;
  owner_t                owner;
  logic [CNT_W-1:0]      wait_cnt;
  owner_t                grant;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  req_any;
`ifdef PDP8_ARB_RR_EN
  logic                  last_exec;
`endif

  assign req_any = ifu_rd_req | exec_rd_req | exec_wr_req;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and infers a latch.
    grant      = OWN_IFU_RD;
    grant_addr = ifu_rd_addr;
    if (exec_wr_req)      grant = OWN_EXEC_WR;
    else if (exec_rd_req) grant = OWN_EXEC_RD;
`ifdef PDP8_ARB_RR_EN
    // Under contention the class that was not served last takes the port.
    if (ifu_rd_req && (exec_wr_req || exec_rd_req) && last_exec) grant = OWN_IFU_RD;
`endif
    case (grant)
      OWN_EXEC_WR: grant_addr = exec_wr_addr;
      OWN_EXEC_RD: grant_addr = exec_rd_addr;
      default:     grant_addr = ifu_rd_addr;
    endcase
  end

  // Combinational so the fetch unit sees the stall in the same cycle it raises its request.
  assign ifu_stall = reset_n & ifu_rd_req & ~((state == S_DONE) && (owner == OWN_IFU_RD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      owner         <= OWN_IFU_RD;
      wait_cnt      <= '0;
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      ifu_rd_data   <= '0;
      ifu_rd_valid  <= 1'b0;
      exec_rd_data  <= '0;
      exec_rd_valid <= 1'b0;
      exec_wr_done  <= 1'b0;
      proto_err     <= 1'b0;
`ifdef PDP8_ARB_RR_EN
      last_exec     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; strobes default low here so each is a single-cycle pulse.
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      ifu_rd_valid  <= 1'b0;
      exec_rd_valid <= 1'b0;
      exec_wr_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            owner    <= grant;
            state    <= S_ISSUE;
            mem_addr <= grant_addr;
            if (grant == OWN_EXEC_WR) begin
              mem_wr_req  <= 1'b1;
              mem_wr_data <= exec_wr_data;
            end else begin
              mem_rd_req  <= 1'b1;
            end
            if (exec_wr_req && exec_rd_req) proto_err <= 1'b1;
`ifdef PDP8_ARB_RR_EN
            last_exec <= (grant != OWN_IFU_RD);
`endif
          end
        end
        S_ISSUE: begin
          if (owner == OWN_EXEC_WR) begin
            exec_wr_done <= 1'b1;
            state        <= S_DONE;
          end else begin
            wait_cnt <= CNT_W'(MEM_RD_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          // Read data is on the bus exactly MEM_RD_LAT cycles after the strobe.
          if (wait_cnt == CNT_W'(1)) begin
            if (owner == OWN_IFU_RD) begin
              ifu_rd_data  <= mem_rd_data;
              ifu_rd_valid <= 1'b1;
            end else begin
              exec_rd_data  <= mem_rd_data;
              exec_rd_valid <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Self-checking bench for pdp8_mem_arbiter: random requester agents, a grant-order reference model and a scoreboard.
// Honours PDP8_ARB_RR_EN in its reference model.
module tb_pdp8_mem_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic [11:0] ifu_rd_data, exec_rd_data, mem_addr, mem_wr_data, mem_rd_data;
  logic        ifu_rd_valid, ifu_stall, exec_rd_valid, exec_wr_done;
  logic        mem_rd_req, mem_wr_req, proto_err;

  // Second instance, MEM_RD_LAT = 4, exercised with a directed read only.
  logic        d4_rd_req;
  logic [11:0] d4_rd_addr, d4_mem_rd_data;
  logic [11:0] d4_ifu_rd_data, d4_exec_rd_data, d4_mem_addr, d4_mem_wr_data;
  logic        d4_ifu_rd_valid, d4_ifu_stall, d4_exec_rd_valid, d4_exec_wr_done;
  logic        d4_mem_rd_req, d4_mem_wr_req, d4_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdp8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .ifu_rd_valid(ifu_rd_valid), .ifu_stall(ifu_stall),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_rd_valid(exec_rd_valid),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_wr_done(exec_wr_done),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .proto_err(proto_err)
  );

  pdp8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_RD_LAT(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(1'b0), .ifu_rd_addr(12'd0), .ifu_rd_data(d4_ifu_rd_data),
    .ifu_rd_valid(d4_ifu_rd_valid), .ifu_stall(d4_ifu_stall),
    .exec_rd_req(d4_rd_req), .exec_rd_addr(d4_rd_addr), .exec_rd_data(d4_exec_rd_data),
    .exec_rd_valid(d4_exec_rd_valid),
    .exec_wr_req(1'b0), .exec_wr_addr(12'd0), .exec_wr_data(12'd0),
    .exec_wr_done(d4_exec_wr_done),
    .mem_rd_req(d4_mem_rd_req), .mem_wr_req(d4_mem_wr_req), .mem_addr(d4_mem_addr),
    .mem_wr_data(d4_mem_wr_data), .mem_rd_data(d4_mem_rd_data), .proto_err(d4_proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model: fixed read latency, garbage on the bus otherwise
  logic [11:0] mem     [4096];
  logic [11:0] ref_mem [4096];
  logic        pv [1:LAT] = '{default: 1'b0};
  logic [11:0] pd [1:LAT] = '{default: 12'd0};
  logic [11:0] garbage = 12'o3333;

  assign mem_rd_data = pv[LAT] ? pd[LAT] : garbage;

  initial forever begin
    @(posedge clk);
    for (int k = LAT; k >= 2; k--) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    pv[1] <= mem_rd_req;
    pd[1] <= mem[mem_addr];
    if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
    garbage <= 12'($urandom);
  end

  // ---------------- reference model: grant order and response timing
  typedef enum int {K_IFU = 0, K_ERD = 1, K_EWR = 2} kind_e;
  typedef struct {
    kind_e       kind;
    logic [11:0] addr;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   next_sample = 0;
  logic exp_proto = 1'b0;
  bit   last_was_exec = 1'b0;

  function automatic kind_e pick_kind();
    kind_e k;
    k = exec_wr_req ? K_EWR : (exec_rd_req ? K_ERD : K_IFU);
`ifdef PDP8_ARB_RR_EN
    if (ifu_rd_req && (exec_wr_req || exec_rd_req) && last_was_exec) k = K_IFU;
`endif
    return k;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      exp_proto     = 1'b0;
      last_was_exec = 1'b0;
      next_sample   = cyc + 1;
    end else if (cyc >= next_sample) begin
      if (ifu_rd_req || exec_rd_req || exec_wr_req) begin
        kind_e k;
        exp_t  e;
        k      = pick_kind();
        e.kind = k;
        e.addr = (k == K_EWR) ? exec_wr_addr : (k == K_ERD) ? exec_rd_addr : ifu_rd_addr;
        if (k == K_EWR) begin
          ref_mem[e.addr] = exec_wr_data;
          e.data      = exec_wr_data;
          e.cyc       = cyc + 2;
          next_sample = cyc + 3;
        end else begin
          e.data      = ref_mem[e.addr];
          e.cyc       = cyc + LAT + 2;
          next_sample = cyc + LAT + 3;
        end
        if (exec_wr_req && exec_rd_req) exp_proto = 1'b1;
        last_was_exec = (k != K_IFU);
        exp_q.push_back(e);
      end else begin
        next_sample = cyc + 1;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- monitor: compares every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      int    npulse;
      int    act_kind;
      exp_t  e;
      check("ifu_stall", ifu_stall, ifu_rd_req & ~ifu_rd_valid);
      check("proto_err", proto_err, exp_proto);
      if (mem_rd_req || mem_wr_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q[0];
          check("strobe_kind", {mem_wr_req, mem_rd_req}, (e.kind == K_EWR) ? 2 : 1);
          check("strobe_cycle", cyc, e.cyc - ((e.kind == K_EWR) ? 1 : LAT + 1));
          check("mem_addr", mem_addr, e.addr);
          if (e.kind == K_EWR) check("mem_wr_data", mem_wr_data, e.data);
        end
      end else begin
        check("mem_bus_idle", {mem_addr, mem_wr_data}, 0);
      end
      npulse = int'(ifu_rd_valid) + int'(exec_rd_valid) + int'(exec_wr_done);
      if (npulse > 1) check("single_pulse", npulse, 1);
      if (npulse != 0) begin
        act_kind = exec_wr_done ? 2 : (exec_rd_valid ? 1 : 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", act_kind + 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", act_kind, int'(e.kind));
          check("pulse_cycle", cyc, e.cyc);
          if (e.kind == K_IFU) check("ifu_rd_data", ifu_rd_data, e.data);
          if (e.kind == K_ERD) check("exec_rd_data", exec_rd_data, e.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missed_pulse", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- requester agents (drive just after the falling edge)
  task automatic wait_sig(input int which, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = ifu_rd_valid;
        1:       seen = exec_rd_valid;
        default: seen = exec_wr_done;
      endcase
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    #1;
  endtask

  task automatic ifu_txn(input logic [11:0] a);
    ifu_rd_addr = a;
    ifu_rd_req  = 1'b1;
    wait_sig(0, "ifu_rd");
    ifu_rd_req  = 1'b0;
  endtask

  task automatic exec_rd_txn(input logic [11:0] a);
    exec_rd_addr = a;
    exec_rd_req  = 1'b1;
    wait_sig(1, "exec_rd");
    exec_rd_req  = 1'b0;
  endtask

  task automatic exec_wr_txn(input logic [11:0] a, input logic [11:0] d);
    exec_wr_addr = a;
    exec_wr_data = d;
    exec_wr_req  = 1'b1;
    wait_sig(2, "exec_wr");
    exec_wr_req  = 1'b0;
  endtask

  // Protocol violation: read and write raised together; write completes first.
  task automatic exec_both_txn(input logic [11:0] wa, input logic [11:0] d, input logic [11:0] ra);
    exec_wr_addr = wa;
    exec_wr_data = d;
    exec_rd_addr = ra;
    exec_wr_req  = 1'b1;
    exec_rd_req  = 1'b1;
    wait_sig(2, "both_wr");
    exec_wr_req  = 1'b0;
    wait_sig(1, "both_rd");
    exec_rd_req  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic any_output();
    return |{mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, ifu_rd_data, ifu_rd_valid,
             ifu_stall, exec_rd_data, exec_rd_valid, exec_wr_done, proto_err};
  endfunction

  // ---------------- main sequence
  initial begin
    reset_n     = 1'b0;
    ifu_rd_req  = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
    ifu_rd_addr = '0;   exec_rd_addr = '0;  exec_wr_addr = '0; exec_wr_data = '0;
    d4_rd_req   = 1'b0; d4_rd_addr = '0;    d4_mem_rd_data = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 12'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[12'o200]     = 12'o7001;
    ref_mem[12'o200] = 12'o7001;

    repeat (3) @(negedge clk);
    check("reset_outputs", any_output(), 1'b0);
    #1 reset_n = 1'b1;

    // Fetch of 12'o200, then a write and a read-back of 12'o050.
    ifu_txn(12'o200);
    check("ifu_data_hold", ifu_rd_data, 12'o7001);
    exec_wr_txn(12'o050, 12'o1234);
    exec_rd_txn(12'o050);
    check("exec_readback", exec_rd_data, 12'o1234);

    // Fetch and exec read raised in the same cycle.
    fork
      ifu_txn(12'o201);
      exec_rd_txn(12'o202);
    join
    gap(1);

    // Read and write together: write first, sticky error, read sees the new value.
    exec_both_txn(12'o060, 12'o5555, 12'o060);
    check("both_readback", exec_rd_data, 12'o5555);
    gap(2);

    // Random concurrent traffic on a small address window to force collisions.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          gap($urandom_range(0, 3));
          ifu_txn(12'($urandom_range(0, 31)));
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          int r;
          gap($urandom_range(0, 3));
          r = $urandom_range(0, 7);
          if (r == 0)
            exec_both_txn(12'($urandom_range(0, 31)), 12'($urandom), 12'($urandom_range(0, 31)));
          else if (r < 4)
            exec_wr_txn(12'($urandom_range(0, 31)), 12'($urandom));
          else
            exec_rd_txn(12'($urandom_range(0, 31)));
        end
      end
    join
    gap(3);

    // Reset during WAIT drops the read with no pulse; then a fresh fetch completes.
    ifu_rd_addr = 12'o200;
    ifu_rd_req  = 1'b1;
    @(negedge clk);
    check("pre_reset_issue", mem_rd_req, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_in_wait_outputs", any_output(), 1'b0);
    ifu_rd_req = 1'b0;
    gap(2);
    reset_n = 1'b1;
    gap(6);
    check("proto_err_cleared", proto_err, 1'b0);
    ifu_txn(12'o200);
    check("post_reset_fetch", ifu_rd_data, 12'o7001);
    gap(2);

    // MEM_RD_LAT = 4 instance: strobe in cycle 1, capture in cycle 5, valid in cycle 6.
    d4_rd_addr = 12'o300;
    d4_rd_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("d4_mem_rd_req", d4_mem_rd_req, (c == 1));
      check("d4_exec_rd_valid", d4_exec_rd_valid, (c == 6));
      if (c == 1) check("d4_mem_addr", d4_mem_addr, 12'o300);
      if (c == 6) check("d4_exec_rd_data", d4_exec_rd_data, 12'o4321);
      #1;
      d4_mem_rd_data = (c == 5) ? 12'o4321 : 12'(c * 12'o111);
      if (c == 6) d4_rd_req = 1'b0;
    end

    gap(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
- Shares the single PDP-8 memory port between the instruction fetch/decode unit (read-only) and the execution unit (read and write).
- Sits between instr_decode/instr_exec and the memory model.
- Sequences each access with an IDLE/ISSUE/WAIT/DONE state machine that counts fixed memory read latency.
- Returns read data and completion pulses to the owning requester, and stalls the losing requester.

Parameters:
- ADDR_WIDTH, 12, memory address width (matches `ADDR_WIDTH)
- DATA_WIDTH, 12, memory data width (matches `DATA_WIDTH)
- MEM_RD_LAT, 1, cycles from mem_rd_req cycle to mem_rd_data valid; legal 1..7

Ports:
- clk  in  1  free-running clock
- reset_n  in  1  asynchronous active-low reset
- ifu_rd_req  in  1  IFD read request, level
- ifu_rd_addr  in  ADDR_WIDTH  IFD read address
- ifu_rd_data  out  DATA_WIDTH  IFD read data, valid with ifu_rd_valid
- ifu_rd_valid  out  1  one-cycle IFD read completion pulse
- ifu_stall  out  1  IFD request pending but not owner
- exec_rd_req  in  1  exec read request, level
- exec_rd_addr  in  ADDR_WIDTH  exec read address
- exec_rd_data  out  DATA_WIDTH  exec read data
- exec_rd_valid  out  1  one-cycle exec read completion pulse
- exec_wr_req  in  1  exec write request, level
- exec_wr_addr  in  ADDR_WIDTH  exec write address
- exec_wr_data  in  DATA_WIDTH  exec write data
- exec_wr_done  out  1  one-cycle exec write completion pulse
- mem_rd_req  out  1  memory read strobe, one cycle
- mem_wr_req  out  1  memory write strobe, one cycle
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory read data
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs are 0: strobes, valids, done, stall, proto_err, data/address registers.
  - Any in-flight access is dropped; no completion pulse is issued for it.
- Requester protocol:
  - Hold req, address and data stable from assertion until its valid/done pulse.
  - Deassert req at the edge where the pulse is sampled.
  - A req high while the arbiter is in IDLE is a new request.
- IDLE:
  - Sample requests and pick the winner by priority: exec_wr > exec_rd > ifu_rd.
  - Latch owner, op and address (and write data) into registers; next state is ISSUE.
  - With no request pending, stay in IDLE.
- ISSUE (1 cycle):
  - mem_addr = latched address.
  - Read: mem_rd_req=1, next state WAIT, wait counter loaded to MEM_RD_LAT.
  - Write: mem_wr_req=1 with mem_wr_data, next state DONE.
- WAIT:
  - Counter decrements each cycle; mem_rd_data is captured into the owner's data register when the counter reaches 1.
  - Next state is DONE.
- DONE (1 cycle):
  - The owner's valid/done pulse is high; the data register holds its value until the next capture.
  - Next state is IDLE.
  - Requests are sampled again only in IDLE, so back-to-back grants are separated by one IDLE cycle.
- Latency:
  - Read: req at cycle 0 → valid in cycle MEM_RD_LAT+2.
  - Write: req at cycle 0 → done in cycle 2.
  - Read throughput: one access per MEM_RD_LAT+3 cycles.
- mem_addr and mem_wr_data are 0 outside ISSUE.
- ifu_stall = ifu_rd_req & ~(owner==IFU & state==DONE).
  - This is combinational from state and the request.
  - It is high in the same cycle as ifu_rd_req while the IFU waits.
- Simultaneous exec_rd_req & exec_wr_req in IDLE:
  - The write is granted.
  - proto_err is set and stays set until reset.
  - The read is then served on the next IDLE.
- A request that changes address mid-transaction is not detected; the latched address is used.
- A request that drops mid-transaction is not detected either; the transaction completes and the pulse is still issued.

Optional Feature:
- Macro: PDP8_ARB_RR_EN.
- Defined:
  - Two-class round-robin between IFU and EXEC, using a 1-bit last_owner register (reset = IFU).
  - On IFU and EXEC contention, the class not served last wins.
  - Within EXEC, write is still above read.
- Undefined: fixed priority as above; the last_owner register is absent.

Test Plan:
- Reset, ifu_rd_req=1 addr 12'o200, memory holds 12'o7001, MEM_RD_LAT=1 → mem_rd_req in cycle 1, ifu_rd_valid in cycle 3 with ifu_rd_data=12'o7001; ifu_stall high in cycles 0-2.
- exec_wr_req addr 12'o050 data 12'o1234 → mem_wr_req cycle 1 with those values, exec_wr_done cycle 2; a follow-up read of 12'o050 returns 12'o1234.
- ifu_rd_req and exec_rd_req both raised in cycle 0 → exec is served first, ifu_rd_valid no earlier than cycle 7, ifu_stall held high throughout; with PDP8_ARB_RR_EN and last_owner=EXEC → IFU is served first.
- exec_rd_req and exec_wr_req both high in IDLE → write is granted first, proto_err=1 and sticky, and the read completes afterward.
- reset_n pulsed low during WAIT → all outputs are 0 immediately and no valid pulse follows; a new ifu request after release completes normally.
- MEM_RD_LAT=4, exec_rd → exec_rd_valid exactly in cycle 6; data captured from mem_rd_data in cycle 5.
